uart_rx_fsm_ctrl: RTL and testbench

Frame controller for the UART receiver. It detects the start edge on `RX_IN` and runs the per-bit edge counter (`EDG_CNT`) that drives the 3-sample majority-vote data sampler. It sequences start, data, parity and stop bits, deserializes `SAMPLED_BIT` LSB-first, checks parity and stop, and emits a one-cycle `DATA_VALID` with the received byte. It sits between the RX pin synchronizer and the RX-side clock-domain FIFO/synchronizer, in the UART RX clock domain.

---
 rtl/uart_rx_fsm_ctrl.sv | 129 ++++++++++++
 tb/tb_uart_rx_fsm_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm_ctrl.sv
// UART RX frame controller: start detection, per-bit edge counting, deserialization, parity/stop checks.
// Optional UART_RX_ERR_CNT_EN adds a saturating ERR_CNT of errored/aborted frames.
module uart_rx_fsm_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  SAMPLED_BIT,
    output logic                  DAT_SAMP_EN,
    output logic [4:0]            EDG_CNT,
    output logic [3:0]            BIT_CNT,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
`ifdef UART_RX_ERR_CNT_EN
    output logic [7:0]            ERR_CNT,
`endif
    output logic                  STP_ERR
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e                r_state, w_nextState;
    logic [4:0]            r_edgCnt, r_edgMax, w_edgMaxNew;
    logic [3:0]            r_bitCnt;
    logic [DATA_WIDTH-1:0] r_shift, r_pData;
    logic                  r_parFlag, r_sampEn, r_dataValid, r_parErr, r_stpErr;
    logic                  w_bitEnd, w_parExp, w_dataValidNxt, w_parErrNxt, w_stpErrNxt;
    logic                  w_unusedPrescale;

    // Only 8/16/32 are legal, so the low prescale bits carry no information.
    assign w_unusedPrescale = &{1'b0, PRESCALE[3:0]};
    assign w_edgMaxNew      = PRESCALE[5] ? 5'd31 : (PRESCALE[4] ? 5'd15 : 5'd7);
    assign w_bitEnd         = (r_state != IDLE) && (r_edgCnt == r_edgMax);
    assign w_parExp         = (^r_shift) ^ PAR_TYP;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (!RX_IN) w_nextState = START;
            START:   if (w_bitEnd) w_nextState = SAMPLED_BIT ? IDLE : DATA;
            DATA:    if (w_bitEnd && (r_bitCnt == 4'(DATA_WIDTH))) w_nextState = PAR_EN ? PARITY : STOP;
            PARITY:  if (w_bitEnd) w_nextState = STOP;
            STOP:    if (w_bitEnd) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        w_dataValidNxt = 1'b0;
        w_parErrNxt    = 1'b0;
        w_stpErrNxt    = 1'b0;
        case (r_state)
            PARITY:  w_parErrNxt = w_bitEnd && (SAMPLED_BIT != w_parExp);
            STOP: begin
                w_stpErrNxt    = w_bitEnd && !SAMPLED_BIT;
                w_dataValidNxt = w_bitEnd && SAMPLED_BIT && !r_parFlag;
            end
            default: ;
        endcase
    end

    // Prescale is frozen at the start edge so mid-frame changes cannot disturb bit timing.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_edgMax    <= 5'd7;
            r_edgCnt    <= '0;
            r_bitCnt    <= '0;
            r_shift     <= '0;
            r_pData     <= '0;
            r_parFlag   <= 1'b0;
            r_sampEn    <= 1'b0;
            r_dataValid <= 1'b0;
            r_parErr    <= 1'b0;
            r_stpErr    <= 1'b0;
        end else begin
            r_sampEn    <= (w_nextState != IDLE);
            r_dataValid <= w_dataValidNxt;
            r_parErr    <= w_parErrNxt;
            r_stpErr    <= w_stpErrNxt;
            if ((r_state == IDLE) && !RX_IN) r_edgMax <= w_edgMaxNew;
            r_edgCnt <= ((r_state == IDLE) || w_bitEnd) ? 5'd0 : r_edgCnt + 5'd1;
            if (w_nextState == IDLE) r_bitCnt <= '0;
            else if (w_bitEnd)       r_bitCnt <= r_bitCnt + 4'd1;
            if ((r_state == DATA) && w_bitEnd) begin
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    if (r_bitCnt == 4'(i + 1)) r_shift[i] <= SAMPLED_BIT;
                end
            end
            if (r_state == IDLE)  r_parFlag <= 1'b0;
            else if (w_parErrNxt) r_parFlag <= 1'b1;
            if (w_dataValidNxt) r_pData <= r_shift;
        end
    end

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] r_errCnt;
    logic       w_frameErr;

    // Parity and stop errors of one frame are both resolved at the stop bit end, so they count once.
    assign w_frameErr = w_bitEnd && (((r_state == START) && SAMPLED_BIT) ||
                                     ((r_state == STOP) && (!SAMPLED_BIT || r_parFlag)));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)                                 r_errCnt <= '0;
        else if (w_frameErr && (r_errCnt != 8'hFF)) r_errCnt <= r_errCnt + 8'd1;
    end

    assign ERR_CNT = r_errCnt;
`endif

    assign DAT_SAMP_EN = r_sampEn;
    assign EDG_CNT     = r_edgCnt;
    assign BIT_CNT     = r_bitCnt;
    assign P_DATA      = r_pData;
    assign DATA_VALID  = r_dataValid;
    assign PAR_ERR     = r_parErr;
    assign STP_ERR     = r_stpErr;

endmodule

// File: tb/tb_uart_rx_fsm_ctrl.sv
// Scoreboard bench for uart_rx_fsm_ctrl: frames push expected strobes, a negedge monitor pops and compares.
module tb_uart_rx_fsm_ctrl;

    localparam int DW = 8;

    logic          CLK, RST, RX_IN, PAR_EN, PAR_TYP, SAMPLED_BIT;
    logic [5:0]    PRESCALE;
    logic          DAT_SAMP_EN, DATA_VALID, PAR_ERR, STP_ERR;
    logic [4:0]    EDG_CNT;
    logic [3:0]    BIT_CNT;
    logic [DW-1:0] P_DATA;
`ifdef UART_RX_ERR_CNT_EN
    logic [7:0]    ERR_CNT;
`endif

    typedef struct {
        int kind;
        int data;
        int cyc;
    } exp_t;

    exp_t sbQ[$];
    int   vectorCnt = 0;
    int   missCnt   = 0;
    int   cycleCnt  = 0;
    int   expErrCnt = 0;
    int   glitchCnt;

    uart_rx_fsm_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .RX_IN       (RX_IN),
        .PRESCALE    (PRESCALE),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .SAMPLED_BIT (SAMPLED_BIT),
        .DAT_SAMP_EN (DAT_SAMP_EN),
        .EDG_CNT     (EDG_CNT),
        .BIT_CNT     (BIT_CNT),
        .P_DATA      (P_DATA),
        .DATA_VALID  (DATA_VALID),
        .PAR_ERR     (PAR_ERR),
`ifdef UART_RX_ERR_CNT_EN
        .ERR_CNT     (ERR_CNT),
`endif
        .STP_ERR     (STP_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectorCnt++;
        if (actual !== expected) begin
            missCnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Strobe kinds: 1 = DATA_VALID, 2 = PAR_ERR, 3 = STP_ERR.
    task automatic checkStrobe(input int kind);
        exp_t e;
        if (sbQ.size() == 0) begin
            checkOutput("unexpected strobe kind", kind, 0);
            return;
        end
        e = sbQ.pop_front();
        checkOutput("strobe kind", kind, e.kind);
        checkOutput("strobe cycle", cycleCnt, e.cyc);
        if (kind == 1) checkOutput("P_DATA on DATA_VALID", 32'(P_DATA), e.data);
        if (kind != 2) checkOutput("DAT_SAMP_EN after stop", 32'(DAT_SAMP_EN), 0);
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            if (PAR_ERR)    checkStrobe(2);
            if (STP_ERR)    checkStrobe(3);
            if (DATA_VALID) checkStrobe(1);
        end
    end

    // Mimics the majority sampler: the voted bit settles mid-bit and holds until the next mid-bit.
    task automatic driveBit(input logic b, input int presc);
        for (int c = 0; c < presc; c++) begin
            if (c == 0) RX_IN = b;
            if (c == presc / 2) SAMPLED_BIT = b;
            @(posedge CLK); #1;
        end
    endtask

    task automatic idleCycles(input int n);
        RX_IN = 1'b1;
        @(posedge CLK); #1;
        SAMPLED_BIT = 1'b1;
        repeat (n - 1) begin
            @(posedge CLK); #1;
        end
    endtask

    // lag is the extra cycle a frame starting right on a stop bit end spends in IDLE.
    task automatic applyStimulus(input logic [7:0] data, input logic parEn, input logic parTyp, input int presc,
                                 input logic flipPar, input logic stopBit, input int lag, input int nBits,
                                 input int altPresc);
        logic [11:0] frame;
        logic        parBit;
        int          nTotal, k0;
        exp_t        e;
        parBit = (^data) ^ parTyp ^ flipPar;
        nTotal = 2 + DW + (parEn ? 1 : 0);
        frame  = '0;
        for (int i = 0; i < DW; i++) frame[1 + i] = data[i];
        if (parEn) frame[1 + DW] = parBit;
        frame[nTotal - 1] = stopBit;
        PAR_EN   = parEn;
        PAR_TYP  = parTyp;
        PRESCALE = 6'(presc);
        k0       = cycleCnt;
        if (nBits >= nTotal) begin
            if (parEn && flipPar) begin
                e = '{kind: 2, data: 0, cyc: k0 + lag + 1 + presc * (DW + 2)};
                sbQ.push_back(e);
            end
            if (!stopBit) begin
                e = '{kind: 3, data: 0, cyc: k0 + lag + 1 + presc * (nTotal)};
                sbQ.push_back(e);
            end else if (!(parEn && flipPar)) begin
                e = '{kind: 1, data: int'(data), cyc: k0 + lag + 1 + presc * (nTotal)};
                sbQ.push_back(e);
            end
            if ((parEn && flipPar) || !stopBit) expErrCnt++;
        end
        for (int j = 0; j < nTotal && j < nBits; j++) begin
            if ((altPresc != 0) && (j == 3)) PRESCALE = 6'(altPresc);
            driveBit(frame[j], presc);
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time limit reached, %0d expectations pending", sbQ.size());
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b0; RX_IN = 1'b1; SAMPLED_BIT = 1'b1;
        PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset DAT_SAMP_EN", 32'(DAT_SAMP_EN), 0);
        checkOutput("reset EDG_CNT", 32'(EDG_CNT), 0);
        checkOutput("reset BIT_CNT", 32'(BIT_CNT), 0);
        checkOutput("reset P_DATA", 32'(P_DATA), 0);
        checkOutput("reset DATA_VALID", 32'(DATA_VALID), 0);
        checkOutput("reset PAR_ERR", 32'(PAR_ERR), 0);
        checkOutput("reset STP_ERR", 32'(STP_ERR), 0);
        RST = 1'b1;
        idleCycles(4);

        $display("[TB] 8E1 prescale 8, 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b0, 8, 1'b0, 1'b1, 0, 99, 0);
        idleCycles(10);

        $display("[TB] 8E1 prescale 8, 0xA5 with parity flipped");
        applyStimulus(8'hA5, 1'b1, 1'b0, 8, 1'b1, 1'b1, 0, 99, 0);
        idleCycles(10);
        checkOutput("P_DATA kept after parity error", 32'(P_DATA), 32'hA5);

        $display("[TB] 8N1 prescale 16, 0x3C with low stop bit");
        applyStimulus(8'h3C, 1'b0, 1'b0, 16, 1'b0, 1'b0, 0, 99, 0);
        idleCycles(20);
        checkOutput("P_DATA kept after stop error", 32'(P_DATA), 32'hA5);

        $display("[TB] two-cycle start glitch at prescale 8");
        PRESCALE = 6'd8;
        RX_IN = 1'b0;
        glitchCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            if (i == 1) RX_IN = 1'b1;
            if (DAT_SAMP_EN) glitchCnt++;
        end
        expErrCnt++;
        checkOutput("glitch DAT_SAMP_EN cycles", glitchCnt, 8);
        checkOutput("glitch BIT_CNT back to idle", 32'(BIT_CNT), 0);
        idleCycles(5);

        $display("[TB] back-to-back 8N1 prescale 32, 0x00 then 0xFF");
        applyStimulus(8'h00, 1'b0, 1'b0, 32, 1'b0, 1'b1, 0, 99, 8);
        applyStimulus(8'hFF, 1'b0, 1'b0, 32, 1'b0, 1'b1, 1, 99, 0);
        idleCycles(10);

        $display("[TB] 8O1 prescale 8, 0x07");
        applyStimulus(8'h07, 1'b1, 1'b1, 8, 1'b0, 1'b1, 0, 99, 0);
        idleCycles(5);

        $display("[TB] 8N1 prescale 8, 0x5A");
        applyStimulus(8'h5A, 1'b0, 1'b0, 8, 1'b0, 1'b1, 0, 99, 0);
        idleCycles(5);
`ifdef UART_RX_ERR_CNT_EN
        checkOutput("ERR_CNT before reset", 32'(ERR_CNT), expErrCnt);
`endif

        $display("[TB] reset during DATA of 0x55, then 0x81");
        applyStimulus(8'h55, 1'b0, 1'b0, 8, 1'b0, 1'b1, 0, 5, 0);
        RST = 1'b0;
        #1;
        checkOutput("mid reset DAT_SAMP_EN", 32'(DAT_SAMP_EN), 0);
        checkOutput("mid reset EDG_CNT", 32'(EDG_CNT), 0);
        checkOutput("mid reset BIT_CNT", 32'(BIT_CNT), 0);
        checkOutput("mid reset P_DATA", 32'(P_DATA), 0);
        checkOutput("mid reset DATA_VALID", 32'(DATA_VALID), 0);
`ifdef UART_RX_ERR_CNT_EN
        checkOutput("mid reset ERR_CNT", 32'(ERR_CNT), 0);
`endif
        expErrCnt = 0;
        RX_IN = 1'b1;
        SAMPLED_BIT = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        idleCycles(4);
        applyStimulus(8'h81, 1'b0, 1'b0, 8, 1'b0, 1'b1, 0, 99, 0);
        idleCycles(10);
        checkOutput("P_DATA after reset recovery", 32'(P_DATA), 32'h81);
        checkOutput("scoreboard entries left", sbQ.size(), 0);
`ifdef UART_RX_ERR_CNT_EN
        checkOutput("ERR_CNT final", 32'(ERR_CNT), expErrCnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorCnt, missCnt);
        $finish;
    end

endmodule
